// File: rtl/cla_multiword_seq.sv
// Multi-word add/subtract sequencer: one 32-bit carry-lookahead adder is reused
// once per word, least-significant word first, with the carry held in a register.

module cla_32_final (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic        co,
  output logic [31:0] s
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  cg;

  assign g = a & b;
  assign p = a ^ b;

  // Two-level lookahead: 4-bit groups form group generate/propagate, group
  // carries are resolved across the eight groups, then bit carries inside each group.
  // NOTE: combinational logic uses blocking assignments; every variable is fully
  // assigned on each pass so no latch is inferred.
  always_comb begin
    gg = '0;
    gp = '0;
    cg = '0;
    c  = '0;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    cg[0] = c_in;
    for (int k = 0; k < 8; k++) begin
      cg[k+1] = gg[k] | (gp[k] & cg[k]);
    end
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = cg[k];
      c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & cg[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
    end
  end

  assign s  = p ^ c;
  assign co = cg[8];

endmodule

module cla_multiword_seq #(
  parameter int WORDS = 2,
  parameter int IDXW  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  c_in,
  input  logic [32*WORDS-1:0]   a,
  input  logic [32*WORDS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [32*WORDS-1:0]   s,
  output logic                  co,
  output logic                  ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [IDXW-1:0]         idx;
  logic                    carry;
  logic                    opsub;
  logic [WORDS-1:0][31:0]  opa;
  logic [WORDS-1:0][31:0]  opb;
  logic [WORDS-1:0][31:0]  s_q;
  logic [31:0]             word_a;
  logic [31:0]             word_b;
  logic [31:0]             add_s;
  logic                    add_co;
  logic                    last;

  assign last = (idx == IDXW'(WORDS - 1));

  // Word select by comparison keeps the index width independent of WORDS.
  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IDXW'(i)) begin
        word_a = opa[i];
        word_b = opb[i] ^ {32{opsub}};
      end
    end
  end

  cla_32_final u_adder (
    .a    (word_a),
    .b    (word_b),
    .c_in (carry),
    .co   (add_co),
    .s    (add_s)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Subtraction is a + ~b + 1, so the carry seed is forced to 1 for sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      opsub <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      s_q   <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            opsub <= sub;
            carry <= sub | c_in;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx == IDXW'(i)) s_q[i] <= add_s;
          end
          carry <= add_co;
          if (last) begin
            co  <= add_co;
            ovf <= (opa[WORDS-1][31] == word_b[31]) && (add_s[31] != opa[WORDS-1][31]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s = s_q;

endmodule
